adsr_envelope: RTL and testbench



---
 rtl/synth_pkg.sv | 24 ++
 rtl/env_sat_step.sv | 59 +++++
 rtl/adsr_envelope.sv | 139 +++++++++++++
 tb/tb_adsr_envelope.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the envelope generator: state codes, full-scale value
// and the step-unit operating modes.
package synth_pkg;

    localparam int unsigned ENV_WIDTH = 32;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_e;

    // How the shared step unit combines the current value with its operand.
    typedef enum logic [1:0] {
        STEP_ADD_MAX   = 2'd0,
        STEP_SUB_LEVEL = 2'd1,
        STEP_SUB_ZERO  = 2'd2,
        STEP_LEVEL     = 2'd3
    } step_mode_e;

endpackage

// File: rtl/env_sat_step.sv
// Combinational saturating add/subtract with clamp; done flags that the segment
// reached its end value (full scale, the sustain level, or zero).
module env_sat_step
    import synth_pkg::*;
#(
    parameter int unsigned WIDTH = ENV_WIDTH
) (
    input  step_mode_e       mode,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] next_val,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, cur} + {1'b0, operand};
        diff     = {1'b0, cur} - {1'b0, operand};
        next_val = cur;
        done     = 1'b0;
        case (mode)
            // A zero rate would stall the segment forever, so it completes immediately.
            STEP_ADD_MAX: begin
                if (sum[WIDTH] || (sum[WIDTH-1:0] == MAX_VAL) || (operand == '0)) begin
                    next_val = MAX_VAL;
                    done     = 1'b1;
                end else begin
                    next_val = sum[WIDTH-1:0];
                end
            end
            STEP_SUB_LEVEL: begin
                if (diff[WIDTH] || (diff[WIDTH-1:0] <= level)) begin
                    next_val = level;
                    done     = 1'b1;
                end else begin
                    next_val = diff[WIDTH-1:0];
                end
            end
            STEP_SUB_ZERO: begin
                if (diff[WIDTH] || (diff[WIDTH-1:0] == '0) || (operand == '0)) begin
                    next_val = '0;
                    done     = 1'b1;
                end else begin
                    next_val = diff[WIDTH-1:0];
                end
            end
            default: begin
                next_val = level;
                done     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/adsr_envelope.sv
// Linear ADSR envelope generator, one step per Env_ce tick, saturating arithmetic.
// Define ENV_EXP_RELEASE_EN for an exponential release (step = max(Amplitude >> EXP_SHIFT, Release_rate)).
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int unsigned WIDTH     = ENV_WIDTH,
    parameter int unsigned EXP_SHIFT = 8
) (
    input  logic             Sys_clk,
    input  logic             Env_rst,
    input  logic             Env_ce,
    input  logic             Gate,
    input  logic [WIDTH-1:0] Attack_rate,
    input  logic [WIDTH-1:0] Decay_rate,
    input  logic [WIDTH-1:0] Sustain_level,
    input  logic [WIDTH-1:0] Release_rate,
    output logic [WIDTH-1:0] Amplitude,
    output logic             Env_busy,
    output logic [2:0]       Env_state
);

`ifdef ENV_EXP_RELEASE_EN
    localparam bit EXP_RELEASE = 1'b1;
`else
    localparam bit EXP_RELEASE = 1'b0;
`endif

    env_state_e       state_q, state_d, seg_state;
    logic [WIDTH-1:0] amp_q, amp_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;

    logic             rise, fall;
    logic [WIDTH-1:0] exp_step, release_step;
    step_mode_e       step_mode;
    logic [WIDTH-1:0] step_operand;
    logic [WIDTH-1:0] step_next;
    logic             step_done;

    // Resolve gate edges first so the same tick also performs the new segment's first step.
    always_comb begin
        rise         = Gate & ~gate_q;
        fall         = ~Gate & gate_q;
        exp_step     = amp_q >> EXP_SHIFT;
        release_step = (EXP_RELEASE && (exp_step > Release_rate)) ? exp_step : Release_rate;

        seg_state = state_q;
        if (rise && ((state_q == ENV_IDLE) || (state_q == ENV_RELEASE))) begin
            seg_state = ENV_ATTACK;
        end else if (fall && ((state_q == ENV_ATTACK) || (state_q == ENV_DECAY) ||
                              (state_q == ENV_SUSTAIN))) begin
            seg_state = ENV_RELEASE;
        end

        step_mode    = STEP_LEVEL;
        step_operand = '0;
        case (seg_state)
            ENV_ATTACK: begin
                step_mode    = STEP_ADD_MAX;
                step_operand = Attack_rate;
            end
            ENV_DECAY: begin
                step_mode    = STEP_SUB_LEVEL;
                step_operand = Decay_rate;
            end
            ENV_RELEASE: begin
                step_mode    = STEP_SUB_ZERO;
                step_operand = release_step;
            end
            default: begin
                step_mode    = STEP_LEVEL;
                step_operand = '0;
            end
        endcase
    end

    env_sat_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode    (step_mode),
        .cur     (amp_q),
        .operand (step_operand),
        .level   (Sustain_level),
        .next_val(step_next),
        .done    (step_done)
    );

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        gate_d  = gate_q;
        busy_d  = busy_q;
        if (Env_ce) begin
            gate_d = Gate;
            case (seg_state)
                ENV_ATTACK: begin
                    amp_d   = step_next;
                    state_d = step_done ? ENV_DECAY : ENV_ATTACK;
                end
                ENV_DECAY: begin
                    amp_d   = step_next;
                    state_d = step_done ? ENV_SUSTAIN : ENV_DECAY;
                end
                ENV_SUSTAIN: begin
                    amp_d   = step_next;
                    state_d = ENV_SUSTAIN;
                end
                ENV_RELEASE: begin
                    amp_d   = step_next;
                    state_d = step_done ? ENV_IDLE : ENV_RELEASE;
                end
                default: begin
                    amp_d   = '0;
                    state_d = ENV_IDLE;
                end
            endcase
            busy_d = (state_d != ENV_IDLE);
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (Env_rst) begin
            state_q <= ENV_IDLE;
            amp_q   <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
        end
    end

    assign Amplitude = amp_q;
    assign Env_busy  = busy_q;
    assign Env_state = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: attack, decay, sustain tracking, release,
// retrigger, Env_ce stall and reset override; exponential release when ENV_EXP_RELEASE_EN is set.
module tb_adsr_envelope;

`ifdef ENV_EXP_RELEASE_EN
    localparam int unsigned SHIFT = 1;
`else
    localparam int unsigned SHIFT = 8;
`endif

    logic        Sys_clk = 1'b0;
    logic        Env_rst;
    logic        Env_ce;
    logic        Gate;
    logic [31:0] Attack_rate;
    logic [31:0] Decay_rate;
    logic [31:0] Sustain_level;
    logic [31:0] Release_rate;
    logic [31:0] Amplitude;
    logic        Env_busy;
    logic [2:0]  Env_state;

    int n_checks = 0;
    int n_pass   = 0;

    adsr_envelope #(
        .WIDTH    (32),
        .EXP_SHIFT(SHIFT)
    ) dut (
        .Sys_clk      (Sys_clk),
        .Env_rst      (Env_rst),
        .Env_ce       (Env_ce),
        .Gate         (Gate),
        .Attack_rate  (Attack_rate),
        .Decay_rate   (Decay_rate),
        .Sustain_level(Sustain_level),
        .Release_rate (Release_rate),
        .Amplitude    (Amplitude),
        .Env_busy     (Env_busy),
        .Env_state    (Env_state)
    );

    always #5 Sys_clk = ~Sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Sys_clk);
        #1;
    endtask

    task automatic check_env(input string tag, input logic [31:0] amp, input logic [2:0] st);
        check_eq({tag, ".amp"}, Amplitude, amp);
        check_eq({tag, ".state"}, {29'd0, Env_state}, {29'd0, st});
        check_eq({tag, ".busy"}, {31'd0, Env_busy}, {31'd0, (st != 3'd0)});
        $display("%-14s amp=%h state=%0d busy=%0d", tag, Amplitude, Env_state, Env_busy);
    endtask

    // From IDLE at 0: four attack ticks then four decay ticks into SUSTAIN at C000_0000.
    task automatic attack_decay();
        Gate = 1'b1;
        tick(); check_env("atk1", 32'h4000_0000, 3'd1);
        tick(); check_env("atk2", 32'h8000_0000, 3'd1);
        tick(); check_env("atk3", 32'hC000_0000, 3'd1);
        tick(); check_env("atk4", 32'hFFFF_FFFF, 3'd2);
        tick(); check_env("dec1", 32'hEFFF_FFFF, 3'd2);
        tick(); check_env("dec2", 32'hDFFF_FFFF, 3'd2);
        tick(); check_env("dec3", 32'hCFFF_FFFF, 3'd2);
        tick(); check_env("dec4", 32'hC000_0000, 3'd3);
    endtask

    initial begin
        Env_rst       = 1'b1;
        Env_ce        = 1'b1;
        Gate          = 1'b0;
        Attack_rate   = 32'h4000_0000;
        Decay_rate    = 32'h1000_0000;
        Sustain_level = 32'hC000_0000;
        Release_rate  = 32'h4000_0000;
        tick(); tick();
        check_env("reset", 32'h0, 3'd0);
        Env_rst = 1'b0;
        tick();
        check_env("idle", 32'h0, 3'd0);

        // Attack with a 10-cycle Env_ce stall after the second step.
        Gate = 1'b1;
        tick(); check_env("atk1", 32'h4000_0000, 3'd1);
        tick(); check_env("atk2", 32'h8000_0000, 3'd1);
        Env_ce = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_env("stall", 32'h8000_0000, 3'd1);
        Env_ce = 1'b1;
        tick(); check_env("atk3", 32'hC000_0000, 3'd1);
        tick(); check_env("atk4", 32'hFFFF_FFFF, 3'd2);
        tick(); check_env("dec1", 32'hEFFF_FFFF, 3'd2);
        tick(); check_env("dec2", 32'hDFFF_FFFF, 3'd2);
        tick(); check_env("dec3", 32'hCFFF_FFFF, 3'd2);
        tick(); check_env("dec4", 32'hC000_0000, 3'd3);
        tick(); check_env("sus_hold", 32'hC000_0000, 3'd3);
        Sustain_level = 32'h2000_0000;
        tick(); check_env("sus_track", 32'h2000_0000, 3'd3);
        Sustain_level = 32'hC000_0000;
        tick(); check_env("sus_back", 32'hC000_0000, 3'd3);

`ifndef ENV_EXP_RELEASE_EN
        // Linear release to IDLE, then retrigger out of RELEASE.
        Gate = 1'b0;
        tick(); check_env("rel1", 32'h8000_0000, 3'd4);
        tick(); check_env("rel2", 32'h4000_0000, 3'd4);
        tick(); check_env("rel3", 32'h0, 3'd0);
        tick(); check_env("idle2", 32'h0, 3'd0);
        attack_decay();
        Gate = 1'b0;
        tick(); check_env("rel_a", 32'h8000_0000, 3'd4);
        Gate = 1'b1;
        tick(); check_env("retrig", 32'hC000_0000, 3'd1);
        Gate = 1'b0;
        tick(); check_env("fall_atk", 32'h8000_0000, 3'd4);
`else
        // Exponential release: halves each tick, minimum step 1 ends it on tick 32.
        Sustain_level = 32'h8000_0000;
        tick(); check_env("sus_8000", 32'h8000_0000, 3'd3);
        Release_rate = 32'h1;
        Gate = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            check_eq("exp_amp", Amplitude, 32'h8000_0000 >> k);
            check_eq("exp_state", {29'd0, Env_state}, 32'd4);
        end
        tick(); check_env("exp_end", 32'h0, 3'd0);
`endif

        // Reset coincident with Env_ce and a rising gate edge wins.
        Gate    = 1'b1;
        Env_rst = 1'b1;
        tick(); check_env("rst_edge", 32'h0, 3'd0);
        Env_rst = 1'b0;
        // gate_q was cleared, so the still-high Gate is seen as a new rise.
        tick(); check_env("post_rst", 32'h4000_0000, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
